// File: rtl/apb_width_bridge.sv
// APB4 width-downsizing bridge: one wide upstream transfer becomes a sequence of
// narrow downstream beats, with strobe-based beat skipping, error abort and PREADY timeout.
module apb_width_bridge #(
  parameter int unsigned ADDR_WIDTH     = 13,
  parameter int unsigned UP_DW          = 32,
  parameter int unsigned DN_DW          = 8,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    s_PSEL,
  input  logic                    s_PENABLE,
  input  logic                    s_PWRITE,
  input  logic [ADDR_WIDTH-1:0]   s_PADDR,
  input  logic [UP_DW-1:0]        s_PWDATA,
  input  logic [UP_DW/8-1:0]      s_PSTRB,
  output logic                    s_PREADY,
  output logic [UP_DW-1:0]        s_PRDATA,
  output logic                    s_PSLVERR,
  output logic                    m_PSEL,
  output logic                    m_PENABLE,
  output logic                    m_PWRITE,
  output logic [ADDR_WIDTH-1:0]   m_PADDR,
  output logic [DN_DW-1:0]        m_PWDATA,
  output logic [DN_DW/8-1:0]      m_PSTRB,
  input  logic                    m_PREADY,
  input  logic [DN_DW-1:0]        m_PRDATA,
  input  logic                    m_PSLVERR
);

  localparam int unsigned RATIO    = UP_DW / DN_DW;
  localparam int unsigned UP_BYTES = UP_DW / 8;
  localparam int unsigned DN_BYTES = DN_DW / 8;
  localparam int unsigned DNB      = $clog2(DN_BYTES);
  localparam int unsigned BW       = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int unsigned TW       = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'(UP_BYTES - 1);

  typedef enum logic [1:0] {IDLE, M_SETUP, M_ACCESS, RESP} state_t;

  // First beat at or after 'from' that must be issued; RATIO when none remain.
  function automatic int unsigned find_beat(input logic [UP_BYTES-1:0] strb,
                                            input logic wr, input int unsigned from);
    int unsigned hit;
    hit = RATIO;
    for (int unsigned i = 0; i < RATIO; i++) begin
      if (hit == RATIO && i >= from && (!wr || (|strb[i*DN_BYTES +: DN_BYTES]))) begin
        hit = i;
      end
    end
    return hit;
  endfunction

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_write;
  logic [UP_DW-1:0]      r_wdata;
  logic [UP_BYTES-1:0]   r_strb;
  logic [BW-1:0]         r_beat, w_beat_nxt;
  logic [TW-1:0]         r_tcnt;
  logic                  w_start, w_err, w_tmo;
  int unsigned           w_hit;

  logic                  r_s_pready, r_s_pslverr, r_m_psel, r_m_penable, r_m_pwrite;
  logic [UP_DW-1:0]      r_s_prdata;
  logic [ADDR_WIDTH-1:0] r_m_paddr;
  logic [DN_DW-1:0]      r_m_pwdata;
  logic [DN_BYTES-1:0]   r_m_pstrb;

  logic [ADDR_WIDTH-1:0] w_src_addr;
  logic                  w_src_write;
  logic [UP_DW-1:0]      w_src_wdata;
  logic [UP_BYTES-1:0]   w_src_strb;

  // The first beat is built straight from the upstream bus, later beats from the latch.
  assign w_src_addr  = (r_state == IDLE) ? s_PADDR  : r_addr;
  assign w_src_write = (r_state == IDLE) ? s_PWRITE : r_write;
  assign w_src_wdata = (r_state == IDLE) ? s_PWDATA : r_wdata;
  assign w_src_strb  = (r_state == IDLE) ? s_PSTRB  : r_strb;

  assign w_tmo = (TIMEOUT_CYCLES != 0) && (r_tcnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    w_start     = 1'b0;
    w_err       = 1'b0;
    w_hit       = RATIO;
    case (r_state)
      IDLE: begin
        if (s_PSEL && s_PENABLE) begin
          w_start = 1'b1;
          w_hit   = find_beat(s_PSTRB, s_PWRITE, 0);
          if ((s_PADDR & LOW_MASK) != '0) begin
            w_state_nxt = RESP;
            w_err       = 1'b1;
          end else if (w_hit == RATIO) begin
            w_state_nxt = RESP;
          end else begin
            w_state_nxt = M_SETUP;
            w_beat_nxt  = BW'(w_hit);
          end
        end
      end
      M_SETUP: w_state_nxt = M_ACCESS;
      M_ACCESS: begin
        if (m_PREADY) begin
          w_hit = find_beat(r_strb, r_write, 32'(r_beat) + 32'd1);
          if (m_PSLVERR) begin
            w_state_nxt = RESP;
            w_err       = 1'b1;
          end else if (w_hit == RATIO) begin
            w_state_nxt = RESP;
          end else begin
            w_state_nxt = M_SETUP;
            w_beat_nxt  = BW'(w_hit);
          end
        end else if (w_tmo) begin
          w_state_nxt = RESP;
          w_err       = 1'b1;
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_addr      <= '0;
      r_write     <= 1'b0;
      r_wdata     <= '0;
      r_strb      <= '0;
      r_beat      <= '0;
      r_tcnt      <= '0;
      r_s_pready  <= 1'b0;
      r_s_pslverr <= 1'b0;
      r_s_prdata  <= '0;
      r_m_psel    <= 1'b0;
      r_m_penable <= 1'b0;
      r_m_pwrite  <= 1'b0;
      r_m_paddr   <= '0;
      r_m_pwdata  <= '0;
      r_m_pstrb   <= '0;
    end else begin
      if (w_start) begin
        r_addr  <= s_PADDR;
        r_write <= s_PWRITE;
        r_wdata <= s_PWDATA;
        r_strb  <= s_PSTRB;
      end
      r_beat <= w_beat_nxt;
      r_tcnt <= (r_state == M_ACCESS && !m_PREADY) ? r_tcnt + TW'(1) : '0;

      r_m_psel    <= (w_state_nxt == M_SETUP) || (w_state_nxt == M_ACCESS);
      r_m_penable <= (w_state_nxt == M_ACCESS);
      if (w_state_nxt == M_SETUP) begin
        r_m_pwrite <= w_src_write;
        r_m_paddr  <= (w_src_addr & ~LOW_MASK) | ADDR_WIDTH'(32'(w_beat_nxt) << DNB);
        r_m_pwdata <= w_src_wdata[32'(w_beat_nxt)*DN_DW +: DN_DW];
        r_m_pstrb  <= w_src_write ? w_src_strb[32'(w_beat_nxt)*DN_BYTES +: DN_BYTES] : '0;
      end

      r_s_pready  <= (w_state_nxt == RESP);
      r_s_pslverr <= (w_state_nxt == RESP) && w_err;
      // Errored beats leave their lane (and all later lanes) at zero.
      if (w_start) begin
        r_s_prdata <= '0;
      end else if (r_state == M_ACCESS && m_PREADY && !m_PSLVERR && !r_write) begin
        r_s_prdata[32'(r_beat)*DN_DW +: DN_DW] <= m_PRDATA;
      end
    end
  end

  assign s_PREADY  = r_s_pready;
  assign s_PSLVERR = r_s_pslverr;
  assign s_PRDATA  = r_s_prdata;
  assign m_PSEL    = r_m_psel;
  assign m_PENABLE = r_m_penable;
  assign m_PWRITE  = r_m_pwrite;
  assign m_PADDR   = r_m_paddr;
  assign m_PWDATA  = r_m_pwdata;
  assign m_PSTRB   = r_m_pstrb;

endmodule

// File: tb/tb_apb_width_bridge.sv
// Bench for apb_width_bridge: directed and random upstream transfers, a byte-memory
// downstream slave with waits/errors/hangs, and a response scoreboard.
module tb_apb_width_bridge;

  localparam int TO = 4;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        s_PSEL, s_PENABLE, s_PWRITE;
  logic [12:0] s_PADDR;
  logic [31:0] s_PWDATA;
  logic [3:0]  s_PSTRB;
  logic        s_PREADY, s_PSLVERR;
  logic [31:0] s_PRDATA;
  logic        m_PSEL, m_PENABLE, m_PWRITE;
  logic [12:0] m_PADDR;
  logic [7:0]  m_PWDATA;
  logic [0:0]  m_PSTRB;
  logic        m_PREADY, m_PSLVERR;
  logic [7:0]  m_PRDATA;

  apb_width_bridge #(.ADDR_WIDTH(13), .UP_DW(32), .DN_DW(8), .TIMEOUT_CYCLES(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .s_PSEL(s_PSEL), .s_PENABLE(s_PENABLE), .s_PWRITE(s_PWRITE), .s_PADDR(s_PADDR),
    .s_PWDATA(s_PWDATA), .s_PSTRB(s_PSTRB), .s_PREADY(s_PREADY), .s_PRDATA(s_PRDATA),
    .s_PSLVERR(s_PSLVERR),
    .m_PSEL(m_PSEL), .m_PENABLE(m_PENABLE), .m_PWRITE(m_PWRITE), .m_PADDR(m_PADDR),
    .m_PWDATA(m_PWDATA), .m_PSTRB(m_PSTRB), .m_PREADY(m_PREADY), .m_PRDATA(m_PRDATA),
    .m_PSLVERR(m_PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  typedef struct { logic [12:0] addr; logic wr; logic [7:0] data; logic strb; } beat_t;
  typedef struct { logic [31:0] rdata; logic err; int cyc; } resp_t;

  beat_t      exp_beats[$];
  resp_t      exp_resp[$];
  logic [7:0] mem     [8192];
  logic [7:0] ref_mem [8192];
  int         n_checks = 0, n_pass = 0, cyc = 0;
  int         g_wait[4];
  int         g_err_at = -1, g_hang_at = -1, g_beat_n = 0, s_cur = 0, s_acc = 0;
  beat_t      sb;
  resp_t      mr;

  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference: which byte lanes become beats, what they cost in cycles, what comes back.
  task automatic model(input logic [12:0] a, input logic wr, input logic [31:0] wd,
                       input logic [3:0] st, output logic [31:0] rd, output logic err,
                       output int cost);
    beat_t b;
    int    n;
    rd = '0; err = 1'b0; cost = 0; n = 0;
    if (a % 4 != 0) begin
      err = 1'b1;
      return;
    end
    for (int i = 0; i < 4; i++) begin
      if (wr && !st[i]) continue;
      b.addr = a + 13'(i);
      b.wr   = wr;
      b.data = wd[8*i +: 8];
      b.strb = wr & st[i];
      exp_beats.push_back(b);
      if (n == g_hang_at) begin
        cost += 1 + TO;
        err = 1'b1;
        return;
      end
      cost += 2 + g_wait[n];
      if (n == g_err_at) begin
        err = 1'b1;
        return;
      end
      if (wr) ref_mem[b.addr] = wd[8*i +: 8];
      else    rd[8*i +: 8] = ref_mem[b.addr];
      n++;
    end
  endtask

  // Downstream slave: checks each beat on its first ACCESS cycle, then answers.
  always @(negedge PCLK) begin
    if (!PRESETn || !(m_PSEL && m_PENABLE)) begin
      m_PREADY = 1'b0; m_PSLVERR = 1'b0; s_acc = 0; m_PRDATA = 8'($urandom);
    end else begin
      if (s_acc == 0) begin
        if (exp_beats.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_beat: got addr 0x%0h, required no beat", m_PADDR);
        end else begin
          sb = exp_beats.pop_front();
          chk("beat_addr", 64'(m_PADDR), 64'(sb.addr));
          chk("beat_dir", 64'(m_PWRITE), 64'(sb.wr));
          chk("beat_strb", 64'(m_PSTRB), 64'(sb.strb));
          if (sb.wr) chk("beat_wdata", 64'(m_PWDATA), 64'(sb.data));
        end
        s_cur = g_beat_n;
        g_beat_n++;
      end
      if (s_cur == g_hang_at || s_cur > 3 || s_acc < g_wait[s_cur]) begin
        m_PREADY = 1'b0; m_PRDATA = 8'($urandom);
      end else begin
        m_PREADY  = 1'b1;
        m_PSLVERR = (s_cur == g_err_at);
        m_PRDATA  = mem[m_PADDR];
        if (m_PWRITE && m_PSTRB[0] && !m_PSLVERR) mem[m_PADDR] = m_PWDATA;
      end
      s_acc++;
    end
  end

  // Response monitor: every s_PREADY pulse consumes one scoreboard entry.
  always @(negedge PCLK) begin
    if (PRESETn && s_PREADY) begin
      if (exp_resp.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_pready: got s_PREADY=1 at cycle %0d, required none", cyc);
      end else begin
        mr = exp_resp.pop_front();
        chk("s_prdata", 64'(s_PRDATA), 64'(mr.rdata));
        chk("s_pslverr", 64'(s_PSLVERR), 64'(mr.err));
        chk("pready_cycle", 64'(cyc), 64'(mr.cyc));
        chk("m_psel_low_at_resp", 64'(m_PSEL), 64'd0);
      end
    end
  end

  task automatic xfer(input logic [12:0] a, input logic wr, input logic [31:0] wd,
                      input logic [3:0] st, input bit drop);
    resp_t r;
    int    cost;
    bit    got;
    g_beat_n = 0;
    model(a, wr, wd, st, r.rdata, r.err, cost);
    s_PSEL = 1'b1; s_PENABLE = 1'b0; s_PWRITE = wr; s_PADDR = a; s_PWDATA = wd; s_PSTRB = st;
    @(posedge PCLK); #1;
    s_PENABLE = 1'b1;
    r.cyc = cyc + 1 + cost;
    exp_resp.push_back(r);
    if (drop) begin
      @(posedge PCLK); #1;
      s_PSEL = 1'b0; s_PENABLE = 1'b0;
    end
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge PCLK);
      if (s_PREADY) got = 1'b1;
    end
    if (!got) begin
      n_checks++;
      $display("FAIL resp_timeout: got no s_PREADY in 200 cycles, required one (addr 0x%0h)", a);
    end
    @(posedge PCLK); #1;
    s_PSEL = 1'b0; s_PENABLE = 1'b0;
    chk("beats_issued", 64'(exp_beats.size()), 64'd0);
    exp_beats.delete();
    repeat ($urandom_range(0, 2)) begin
      @(posedge PCLK); #1;
    end
  endtask

  task automatic set_slave(input int w, input int err_at, input int hang_at);
    for (int k = 0; k < 4; k++) g_wait[k] = w;
    g_err_at = err_at; g_hang_at = hang_at;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test by %0t, required completion", $time);
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        err;
    int          cost;
    bit          got;
    logic [12:0] a;
    logic [3:0]  st;

    PRESETn = 1'b0;
    s_PSEL = 1'b0; s_PENABLE = 1'b0; s_PWRITE = 1'b0;
    s_PADDR = '0; s_PWDATA = '0; s_PSTRB = '0;
    m_PREADY = 1'b0; m_PSLVERR = 1'b0; m_PRDATA = '0;
    for (int i = 0; i < 8192; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    for (int i = 0; i < 4; i++) begin
      mem[16 + i] = 8'(8'h11 * (i + 1));
      ref_mem[16 + i] = mem[16 + i];
    end
    set_slave(0, -1, -1);

    repeat (3) @(posedge PCLK);
    #1;
    chk("reset_outputs",
        64'({s_PREADY, s_PSLVERR, s_PRDATA, m_PSEL, m_PENABLE, m_PWRITE, m_PADDR, m_PWDATA, m_PSTRB}),
        64'd0);
    @(negedge PCLK); PRESETn = 1'b1;
    @(posedge PCLK); #1;

    xfer(13'h010, 1'b0, 32'h0, 4'h0, 1'b0);                 // four-beat read
    xfer(13'h020, 1'b1, 32'hAABBCCDD, 4'b0101, 1'b0);       // sparse write
    xfer(13'h013, 1'b0, 32'h0, 4'h0, 1'b0);                 // unaligned
    set_slave(0, 1, -1);
    xfer(13'h040, 1'b0, 32'h0, 4'h0, 1'b0);                 // error on beat 1
    set_slave(0, -1, 0);
    xfer(13'h050, 1'b0, 32'h0, 4'h0, 1'b0);                 // downstream hang
    set_slave(0, -1, -1);
    xfer(13'h060, 1'b1, 32'h12345678, 4'h0, 1'b0);          // write with no strobes
    xfer(13'h020, 1'b0, 32'h0, 4'h0, 1'b0);                 // read back sparse write

    // Reset while the third beat of a full write is in flight.
    g_beat_n = 0;
    model(13'h100, 1'b1, 32'h01020304, 4'hF, rd, err, cost);
    s_PSEL = 1'b1; s_PENABLE = 1'b0; s_PWRITE = 1'b1; s_PADDR = 13'h100;
    s_PWDATA = 32'h01020304; s_PSTRB = 4'hF;
    @(posedge PCLK); #1;
    s_PENABLE = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge PCLK); #2;
      if (g_beat_n >= 3) got = 1'b1;
    end
    if (!got) begin
      n_checks++;
      $display("FAIL midreset_wait: got %0d beats started, required 3", g_beat_n);
    end
    PRESETn = 1'b0;
    #1;
    chk("midreset_outputs",
        64'({s_PREADY, s_PSLVERR, s_PRDATA, m_PSEL, m_PENABLE, m_PWRITE, m_PADDR, m_PWDATA, m_PSTRB}),
        64'd0);
    s_PSEL = 1'b0; s_PENABLE = 1'b0;
    repeat (2) @(posedge PCLK);
    @(negedge PCLK); PRESETn = 1'b1;
    @(posedge PCLK); #1;
    exp_beats.delete();
    xfer(13'h010, 1'b0, 32'h0, 4'h0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      a = 13'($urandom_range(32'h200, 32'h1FFF));
      if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
      st = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
      for (int k = 0; k < 4; k++) g_wait[k] = int'($urandom_range(0, 2));
      g_err_at  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : -1;
      g_hang_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1;
      xfer(a, 1'($urandom), $urandom, st, $urandom_range(0, 5) == 0);
    end

    repeat (5) @(posedge PCLK);
    #1;
    chk("resp_queue_drained", 64'(exp_resp.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
